gb_microseq: RTL
================

Name: gb_microseq

Overview:
- Microcode sequencer driving the 9-bit micro-op address into the microcode ROM, and consuming its 65-bit control word combinationally in the same cycle.
- Fetches instruction bytes over a req/ack handshake and handles the 0xCB prefix.
- Walks linked micro-op chains, stalls on memory micro-ops and terminates on condition failure.
- Sits between the fetch/bus unit and the datapath in the CPU core.

Parameters:
- CW_WIDTH, 65, control word width.
- MAX_UOPS, 16, retire limit per instruction before fault abort.
- CB_OPCODE, 8'hCB, prefix byte value.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- fetch_req  out  1  request next instruction byte at PC
- fetch_ack  in  1  byte valid on fetch_data this cycle
- fetch_data  in  8  fetched instruction byte
- pc_inc  out  1  one-cycle pulse: advance PC
- uop_addr  out  9  micro-op address to microcode ROM
- control_signals  in  65  ROM control word for current uop_addr
- uop_valid  out  1  current control word retires this cycle
- mem_done  in  1  memory access of current micro-op complete
- cond_true  in  1  datapath condition (flags) result
- instr_done  out  1  one-cycle pulse at instruction end
- cb_prefix  out  1  current instruction is CB-prefixed
- uop_fault  out  1  sticky, MAX_UOPS exceeded; cleared by rst only

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Control word fields interpreted here (all other bits pass through to the datapath):
  - [64] last
  - [63] mem_stall
  - [62] cond_chk
  - [61] halt
  - [8:0] next
- Reset values: all outputs 0, state IDLE, step counter 0.
- rst mid-instruction discards all progress. The next state is IDLE.
- States: IDLE, FETCH, EXEC, HALTED (HALTED exists only with the option).
- IDLE: go to FETCH the next cycle.
- FETCH:
  - fetch_req=1, held until fetch_ack.
  - On the ack cycle: pc_inc=1 for exactly that cycle.
  - If fetch_data==CB_OPCODE and cb_prefix==0: set cb_prefix=1, stay in FETCH. fetch_req deasserts for one cycle, then reasserts.
  - Otherwise: uop_addr<={cb_prefix, fetch_data}, step<=0, go to EXEC.
  - A second 0xCB while cb_prefix=1 is a normal opcode and indexes entry 0x1CB.
- EXEC:
  - Retire condition: retire = !mem_stall || mem_done.
  - uop_valid = retire (combinational from the current control word).
  - If not retiring: hold uop_addr; the stall length is unbounded.
  - On retire, the end condition is last || (cond_chk && !cond_true).
  - If end: instr_done=1 next cycle, cb_prefix<=0, go to FETCH.
  - Otherwise: uop_addr<=next, step<=step+1.
  - If step+1==MAX_UOPS and not end: set uop_fault, clear cb_prefix, go to FETCH. instr_done is not pulsed.
- cond_chk on a micro-op that is also last ends the instruction regardless of cond_true.
- halt bit without the option: ignored.
- fetch_req is never asserted in EXEC. uop_valid is never asserted outside EXEC.
- Latency:
  - Fetch ack to first uop_valid: 1 cycle minimum.
  - Last retire to next fetch_req: 1 cycle.
- Timing constraint: the ROM is combinational, so control_signals is sampled in the same cycle uop_addr is presented.

Optional Feature:
- Macro: GB_MICROSEQ_HALT_EN.
- Enabled:
  - Adds input wake (1 bit) and output halted (1 bit, reset 0).
  - When a retiring micro-op has the halt bit set: go to HALTED, halted=1, instr_done pulses, cb_prefix clears.
  - In HALTED: no fetch_req. On wake=1, go to FETCH the next cycle and set halted=0.
  - wake sampled while not HALTED is ignored.
- Disabled: no wake/halted ports, no HALTED state, halt bit ignored.

Test Plan:
- Single-uop instruction: rst, then ack with fetch_data=8'h00, ROM[0x000] last=1 -> uop_addr=0x000, one uop_valid, instr_done 1 cycle later, then fetch_req reasserts; pc_inc pulses exactly once.
- CB prefix: ack 8'hCB then 8'h37 -> pc_inc twice, cb_prefix=1, uop_addr=0x137; cb_prefix=0 after instr_done.
- Memory stall: micro-op with mem_stall=1 and mem_done low for 5 cycles -> uop_addr held, uop_valid=0 for 5 cycles, then uop_valid=1 on the mem_done cycle and uop_addr advances to next.
- Conditional abort: chain 0x020->0x1C0 with cond_chk=1 at 0x020, cond_true=0 -> instr_done after 1 retire, 0x1C0 never presented; with cond_true=1 -> both presented.
- Fault: chain that loops on itself (next=own address, last=0), MAX_UOPS=16 -> exactly 16 uop_valid pulses, then uop_fault=1, fetch resumes, no instr_done.
- Halt (GB_MICROSEQ_HALT_EN): halt uop retires -> halted=1 and no fetch_req for 10 cycles; wake=1 -> fetch_req the next cycle; rst mid-EXEC -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/gb_microseq.sv
// gb_microseq: fetches opcode bytes (with 0xCB prefix) and walks linked micro-op chains in the microcode ROM.
// Define GB_MICROSEQ_HALT_EN to add the HALTED state with wake/halted ports.
module gb_microseq #(
    parameter int         CW_WIDTH  = 65,
    parameter int         MAX_UOPS  = 16,
    parameter logic [7:0] CB_OPCODE = 8'hCB
) (
    input  logic                clk,
    input  logic                rst,
    output logic                fetch_req,
    input  logic                fetch_ack,
    input  logic [7:0]          fetch_data,
    output logic                pc_inc,
    output logic [8:0]          uop_addr,
    input  logic [CW_WIDTH-1:0] control_signals,
    output logic                uop_valid,
    input  logic                mem_done,
    input  logic                cond_true,
    output logic                instr_done,
    output logic                cb_prefix,
`ifdef GB_MICROSEQ_HALT_EN
    input  logic                wake,
    output logic                halted,
`endif
    output logic                uop_fault
);
    localparam int STEP_W = $clog2(MAX_UOPS + 1);

`ifdef GB_MICROSEQ_HALT_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;
`endif

    state_t            r_state;
    logic              r_fetch_req;
    logic              r_instr_done;
    logic              r_cb_prefix;
    logic              r_uop_fault;
    logic [8:0]        r_uop_addr;
    logic [STEP_W-1:0] r_step;
`ifdef GB_MICROSEQ_HALT_EN
    logic              r_halted;
    logic              w_halt;
`endif

    logic              w_last;
    logic              w_mem_stall;
    logic              w_cond_chk;
    logic [8:0]        w_next;
    logic              w_retire;
    logic              w_end;
    logic              w_ack;
    logic              w_is_prefix;
    logic              w_limit;
    logic [STEP_W-1:0] w_step_nxt;
    logic              w_unused_cw;

    assign w_last      = control_signals[CW_WIDTH-1];
    assign w_mem_stall = control_signals[CW_WIDTH-2];
    assign w_cond_chk  = control_signals[CW_WIDTH-3];
    assign w_next      = control_signals[8:0];
`ifdef GB_MICROSEQ_HALT_EN
    assign w_halt      = control_signals[CW_WIDTH-4];
`endif
    // Remaining control bits belong to the datapath.
    assign w_unused_cw = ^control_signals[CW_WIDTH-4:9];

    // The ROM is combinational: the word for r_uop_addr is decoded in the same cycle.
    assign w_retire    = (r_state == S_EXEC) && (!w_mem_stall || mem_done);
    assign w_end       = w_last || (w_cond_chk && !cond_true);
    assign w_ack       = (r_state == S_FETCH) && r_fetch_req && fetch_ack;
    assign w_is_prefix = (fetch_data == CB_OPCODE) && !r_cb_prefix;
    assign w_step_nxt  = r_step + STEP_W'(1);
    assign w_limit     = (w_step_nxt == STEP_W'(MAX_UOPS));

    assign fetch_req  = r_fetch_req;
    assign pc_inc     = w_ack;
    assign uop_addr   = r_uop_addr;
    assign uop_valid  = w_retire;
    assign instr_done = r_instr_done;
    assign cb_prefix  = r_cb_prefix;
    assign uop_fault  = r_uop_fault;
`ifdef GB_MICROSEQ_HALT_EN
    assign halted     = r_halted;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fetch_req  <= 1'b0;
            r_instr_done <= 1'b0;
            r_cb_prefix  <= 1'b0;
            r_uop_fault  <= 1'b0;
            r_uop_addr   <= 9'h000;
            r_step       <= '0;
`ifdef GB_MICROSEQ_HALT_EN
            r_halted     <= 1'b0;
`endif
        end else begin
            r_instr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_FETCH;
                    r_fetch_req <= 1'b1;
                end
                S_FETCH: begin
                    // After a prefix byte the request drops for one cycle before the opcode fetch.
                    if (!r_fetch_req) begin
                        r_fetch_req <= 1'b1;
                    end else if (fetch_ack) begin
                        r_fetch_req <= 1'b0;
                        if (w_is_prefix) begin
                            r_cb_prefix <= 1'b1;
                        end else begin
                            r_uop_addr <= {r_cb_prefix, fetch_data};
                            r_step     <= '0;
                            r_state    <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_retire) begin
`ifdef GB_MICROSEQ_HALT_EN
                        if (w_halt) begin
                            r_state      <= S_HALTED;
                            r_halted     <= 1'b1;
                            r_instr_done <= 1'b1;
                            r_cb_prefix  <= 1'b0;
                        end else
`endif
                        if (w_end) begin
                            r_state      <= S_FETCH;
                            r_fetch_req  <= 1'b1;
                            r_instr_done <= 1'b1;
                            r_cb_prefix  <= 1'b0;
                        end else if (w_limit) begin
                            // Runaway chain: abort without signalling completion.
                            r_state     <= S_FETCH;
                            r_fetch_req <= 1'b1;
                            r_uop_fault <= 1'b1;
                            r_cb_prefix <= 1'b0;
                        end else begin
                            r_uop_addr <= w_next;
                            r_step     <= w_step_nxt;
                        end
                    end
                end
`ifdef GB_MICROSEQ_HALT_EN
                S_HALTED: begin
                    if (wake) begin
                        r_state     <= S_FETCH;
                        r_fetch_req <= 1'b1;
                        r_halted    <= 1'b0;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
